// File: rtl/decomp_seq_ctrl.sv
// decomp_seq_ctrl: packet sequencer that parses the primary header and meters payload words into the decompression datapath
module decomp_seq_ctrl #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [4:0]  j,
  input  logic [4:0]  k,
  input  logic [4:0]  n,
  input  logic        dp_ready,
  output logic [31:0] dp_data,
  output logic        dp_valid,
  output logic        dp_first,
  output logic        cds_start,
  output logic        cds_end,
  output logic [4:0]  j_o,
  output logic [4:0]  k_o,
  output logic [4:0]  n_o,
  output logic [47:0] hdr_out,
  output logic        hdr_valid,
  output logic        pkt_done,
  output logic        pkt_err
);
  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DISCARD} state_e;
  state_e      state_q;
  logic [31:0] hdr0_q, dp_data_q;
  logic [47:0] hdr_q;
  logic [15:0] len_q, wc_q;
  logic [4:0]  cc_q, nm1_q, j_q, k_q, n_q;
  logic        dp_valid_q, dp_first_q, cds_start_q, cds_end_q, hdr_valid_q, pkt_done_q, pkt_err_q;
  logic [16:0] len1;
  logic        xfer, last;
  assign s_ready = !reset && (state_q == PAYLOAD ? dp_ready : 1'b1);
  assign xfer    = s_valid && s_ready;
  assign len1    = {1'b0, s_data[15:0]} + 17'd1;
  assign last    = wc_q == len_q;
  // n==0 means a 32-word CDS; the 5-bit n-1 wraps to 31 on its own
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hdr0_q      <= '0;
      hdr_q       <= '0;
      len_q       <= '0;
      wc_q        <= '0;
      cc_q        <= '0;
      nm1_q       <= '0;
      j_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      dp_data_q   <= '0;
      dp_valid_q  <= 1'b0;
      dp_first_q  <= 1'b0;
      cds_start_q <= 1'b0;
      cds_end_q   <= 1'b0;
      hdr_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      dp_valid_q  <= 1'b0;
      dp_first_q  <= 1'b0;
      cds_start_q <= 1'b0;
      cds_end_q   <= 1'b0;
      hdr_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      if (xfer) begin
        case (state_q)
          IDLE: begin
            hdr0_q  <= s_data;
            state_q <= HDR1;
          end
          HDR1: begin
            hdr_q       <= {hdr0_q, s_data[31:16]};
            len_q       <= s_data[15:0];
            j_q         <= j;
            k_q         <= k;
            n_q         <= n;
            nm1_q       <= n - 5'd1;
            wc_q        <= '0;
            cc_q        <= '0;
            hdr_valid_q <= 1'b1;
            state_q     <= len1 > 17'(MAX_WORDS) ? DISCARD : PAYLOAD;
          end
          PAYLOAD: begin
            dp_data_q   <= s_data;
            dp_valid_q  <= 1'b1;
            dp_first_q  <= wc_q == '0;
            cds_start_q <= cc_q == '0;
            cds_end_q   <= cc_q == nm1_q || last;
            wc_q        <= wc_q + 16'd1;
            cc_q        <= cc_q == nm1_q ? 5'd0 : cc_q + 5'd1;
            pkt_done_q  <= last;
            state_q     <= last ? IDLE : PAYLOAD;
          end
          default: begin
            wc_q      <= wc_q + 16'd1;
            pkt_err_q <= last;
            state_q   <= last ? IDLE : DISCARD;
          end
        endcase
      end
    end
  end
  assign dp_data   = dp_data_q;
  assign dp_valid  = dp_valid_q;
  assign dp_first  = dp_first_q;
  assign cds_start = cds_start_q;
  assign cds_end   = cds_end_q;
  assign j_o       = j_q;
  assign k_o       = k_q;
  assign n_o       = n_q;
  assign hdr_out   = hdr_q;
  assign hdr_valid = hdr_valid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_err   = pkt_err_q;
endmodule

// File: tb/tb_decomp_seq_ctrl.sv
// tb_decomp_seq_ctrl: directed self-checking bench for decomp_seq_ctrl
module tb_decomp_seq_ctrl;
  logic clk = 0, reset = 1, s_valid = 0, dp_ready = 1, s_ready;
  logic [31:0] s_data = 0, dp_data;
  logic [4:0] j = 0, k = 0, n = 0, j_o, k_o, n_o;
  logic dp_valid, dp_first, cds_start, cds_end, hdr_valid, pkt_done, pkt_err;
  logic [47:0] hdr_out;

  decomp_seq_ctrl dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .j(j), .k(k), .n(n), .dp_ready(dp_ready), .dp_data(dp_data), .dp_valid(dp_valid),
    .dp_first(dp_first), .cds_start(cds_start), .cds_end(cds_end),
    .j_o(j_o), .k_o(k_o), .n_o(n_o), .hdr_out(hdr_out), .hdr_valid(hdr_valid),
    .pkt_done(pkt_done), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; logic f, cs, ce, done; int c;} beat_t;
  beat_t beats[$];
  int hv_cyc[$];
  logic [47:0] hv_hdr;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, err_cnt = 0;
  bit tog = 0, track = 0;
  int tc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dp_valid) beats.push_back('{dp_data, dp_first, cds_start, cds_end, pkt_done, cyc});
    if (pkt_done) done_cnt++;
    if (pkt_err) err_cnt++;
    if (hdr_valid) begin
      hv_cyc.push_back(cyc);
      hv_hdr = hdr_out;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    bit acc = 0;
    int t = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      s_data = w;
      s_valid = 1;
      dp_ready = tog ? (tc % 3 == 0) : 1'b1;
      tc++;
      #1 acc = s_ready;
      if (track) chk("s_ready_track", s_ready, dp_ready);
      t++;
    end
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic pkt(input logic [31:0] w0, input logic [31:0] w1, input int nw, input logic [31:0] base);
    push(w0);
    push(w1);
    track = tog;
    for (int i = 0; i < nw; i++) push(base + i);
    track = 0;
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      s_valid = 0;
      dp_ready = 1;
    end
  endtask

  task automatic clear();
    beats.delete();
    hv_cyc.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_hdr_out", hdr_out, 0);
    chk("rst_cfg", {j_o, k_o, n_o}, 0);
    chk("rst_pulses", {hdr_valid, pkt_done, pkt_err, dp_first, cds_start, cds_end}, 0);
    chk("rst_dp_data", dp_data, 0);
    @(negedge clk);
    reset = 0;
    #1 chk("idle_s_ready", s_ready, 1);

    // basic 4-word packet, n=2
    j = 5'd8; k = 5'd3; n = 5'd2;
    pkt(32'h0800_C000, 32'h0003_0003, 4, 32'hA0);
    idle(3);
    chk("p1_hdr", hv_hdr, 48'h0800C0000003);
    chk("p1_hv_cnt", hv_cyc.size(), 1);
    chk("p1_beats", beats.size(), 4);
    if (beats.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("p1_data", beats[i].d, 32'hA0 + i);
        chk("p1_flags", {beats[i].f, beats[i].cs, beats[i].ce, beats[i].done},
            {i == 0, i % 2 == 0, i % 2 == 1, i == 3});
      end
      chk("p1_consec", beats[3].c - beats[0].c, 3);
      chk("p1_hv_lat", beats[0].c - hv_cyc[0], 1);
    end
    chk("p1_done_cnt", done_cnt, 1);
    chk("p1_cfg", {j_o, k_o, n_o}, {5'd8, 5'd3, 5'd2});

    // same packet with dp_ready toggling
    clear();
    tog = 1;
    pkt(32'h0800_C000, 32'h0003_0003, 4, 32'hA0);
    tog = 0;
    idle(3);
    chk("p2_beats", beats.size(), 4);
    if (beats.size() == 4)
      for (int i = 0; i < 4; i++) chk("p2_data", beats[i].d, 32'hA0 + i);
    chk("p2_done_cnt", done_cnt, 1);

    // L=0 packet followed back-to-back by an L=1 packet
    clear();
    pkt(32'h1111_0000, 32'h2222_0000, 1, 32'h50);
    pkt(32'h3333_0000, 32'h4444_0001, 2, 32'h60);
    idle(3);
    chk("p3_beats", beats.size(), 3);
    chk("p3_hv_cnt", hv_cyc.size(), 2);
    if (beats.size() == 3 && hv_cyc.size() == 2) begin
      chk("p3_single", {beats[0].f, beats[0].cs, beats[0].ce, beats[0].done}, 4'hF);
      chk("p3_hv2_gap", hv_cyc[1] - beats[0].c, 2);
      chk("p3_data", beats[2].d, 32'h61);
      chk("p3_last", {beats[2].f, beats[2].ce, beats[2].done}, 3'b011);
    end
    chk("p3_done_cnt", done_cnt, 2);

    // one word over MAX_WORDS is discarded
    clear();
    pkt(32'hDEAD_BEEF, 32'h0000_0400, 1025, 32'h1000);
    idle(3);
    chk("p4_no_dp", beats.size(), 0);
    chk("p4_err_cnt", err_cnt, 1);
    chk("p4_done_cnt", done_cnt, 0);
    clear();
    pkt(32'h0102_0304, 32'h0506_0003, 4, 32'hB0);
    idle(3);
    chk("p4b_beats", beats.size(), 4);
    chk("p4b_done", done_cnt, 1);
    chk("p4b_err", err_cnt, 0);

    // exactly MAX_WORDS is forwarded
    clear();
    pkt(32'h0A0B_0C0D, 32'h0E0F_03FF, 1024, 32'h2000);
    idle(3);
    chk("p5_beats", beats.size(), 1024);
    if (beats.size() == 1024) begin
      chk("p5_last_data", beats[1023].d, 32'h2000 + 1023);
      chk("p5_last_flags", {beats[1023].ce, beats[1023].done}, 2'b11);
    end
    chk("p5_err", err_cnt, 0);
    chk("p5_done", done_cnt, 1);

    // n=0 => 32-word CDS, config changed mid-packet
    clear();
    j = 5'd1; k = 5'd2; n = 5'd0;
    push(32'hCAFE_0000);
    push(32'hF00D_0027);
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin j = 5'd3; k = 5'd4; n = 5'd5; end
      push(32'h300 + i);
    end
    idle(3);
    chk("p6_beats", beats.size(), 40);
    if (beats.size() == 40)
      for (int i = 0; i < 40; i++) begin
        chk("p6_cs", beats[i].cs, i == 0 || i == 32);
        chk("p6_ce", beats[i].ce, i == 31 || i == 39);
      end
    chk("p6_cfg_hold", {j_o, k_o, n_o}, {5'd1, 5'd2, 5'd0});
    pkt(32'h1234_5678, 32'h9ABC_0000, 1, 32'h400);
    idle(3);
    chk("p6_cfg_new", {j_o, k_o, n_o}, {5'd3, 5'd4, 5'd5});

    // reset mid-packet
    clear();
    push(32'hABCD_0000);
    push(32'h1234_0003);
    push(32'hD0);
    push(32'hD1);
    @(negedge clk);
    s_valid = 0;
    reset = 1;
    #1 chk("p7_rst_ready", s_ready, 0);
    @(negedge clk);
    reset = 0;
    idle(2);
    chk("p7_beats", beats.size(), 2);
    chk("p7_no_done", done_cnt, 0);
    pkt(32'h5555_6666, 32'h7777_0000, 1, 32'hE0);
    idle(3);
    chk("p7_hdr", hv_hdr, 48'h555566667777);
    chk("p7_beats2", beats.size(), 3);
    if (beats.size() == 3) chk("p7_data", beats[2].d, 32'hE0);
    chk("p7_done", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
